sr_display_receiver: RTL

Serial-to-parallel receiver for the 7-segment shift-register link driven by the calculator's output driver (`sr_data`/`sr_clk`/`sr_latch`). It oversamples the three link lines in the system clock domain and shifts in one byte per display. On each latch it validates the bit count, captures the frame, and decodes every byte back to a hex digit. It presents the result on a valid/ready handshake, for use as a loop-back checker or as the front end of a downstream display controller.

---
 rtl/sr_display_receiver.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sr_display_receiver.sv
// Serial-to-parallel receiver for the 7-segment shift-register link.
// Oversamples sr_data/sr_clk/sr_latch, captures frames, decodes hex digits.
module sr_display_receiver #(
   parameter int NUM_7_SEG_DISPLAYS = 5,
   parameter int SYNC_STAGES        = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              i_sr_data,
   input  logic                              i_sr_clk,
   input  logic                              i_sr_latch,
   output logic [8*NUM_7_SEG_DISPLAYS-1:0]   o_frame,
   output logic [4*NUM_7_SEG_DISPLAYS-1:0]   o_digits,
   output logic [NUM_7_SEG_DISPLAYS-1:0]     o_digit_valid,
   output logic [NUM_7_SEG_DISPLAYS-1:0]     o_minus,
   output logic                              o_valid,
   input  logic                              i_ready,
   output logic                              o_frame_error,
   output logic                              o_overrun
);

   localparam int N  = NUM_7_SEG_DISPLAYS;
   localparam int FW = 8 * N;
   localparam int CW = $clog2(FW + 2);

   // Result layout: {minus, digit_valid, digit[3:0]}
   function automatic logic [5:0] f_dec(input logic [6:0] seg);
      logic [5:0] r;
      r = '0;
      case (seg)
         7'h3F: r = 6'h10;
         7'h06: r = 6'h11;
         7'h5B: r = 6'h12;
         7'h4F: r = 6'h13;
         7'h66: r = 6'h14;
         7'h6D: r = 6'h15;
         7'h7D: r = 6'h16;
         7'h07: r = 6'h17;
         7'h7F: r = 6'h18;
         7'h6F: r = 6'h19;
         7'h77: r = 6'h1A;
         7'h7C: r = 6'h1B;
         7'h39: r = 6'h1C;
         7'h5E: r = 6'h1D;
         7'h79: r = 6'h1E;
         7'h71: r = 6'h1F;
         7'h40: r = 6'h20;
         default: r = '0;
      endcase
      return r;
   endfunction

   logic [SYNC_STAGES-1:0] r_sd;
   logic [SYNC_STAGES-1:0] r_sc;
   logic [SYNC_STAGES-1:0] r_sl;
   logic                   r_sc_h;
   logic                   r_sl_h;
   logic [FW-1:0]          r_shreg;
   logic [CW-1:0]          r_cnt;

   logic                   w_data;
   logic                   w_shift;
   logic                   w_latch;
   logic                   w_load;
   logic [FW-1:0]          w_shreg_nxt;
   logic [CW-1:0]          w_cnt_nxt;
   logic [4*N-1:0]         w_digits;
   logic [N-1:0]           w_dv;
   logic [N-1:0]           w_minus;

   assign w_data  = r_sd[SYNC_STAGES-1];
   assign w_shift = r_sc[SYNC_STAGES-1] & ~r_sc_h;
   assign w_latch = r_sl[SYNC_STAGES-1] & ~r_sl_h;

   // A coincident shift is applied before the latch looks at shreg/count
   always_comb begin
      w_shreg_nxt = r_shreg;
      w_cnt_nxt   = r_cnt;
      if (w_shift) begin
         w_shreg_nxt = {r_shreg[FW-2:0], w_data};
         if (r_cnt != CW'(FW + 1))
            w_cnt_nxt = r_cnt + 1'b1;
      end
   end

   assign w_load = w_latch & (w_cnt_nxt == CW'(FW));

   always_comb begin
      w_digits = '0;
      w_dv     = '0;
      w_minus  = '0;
      for (int k = 0; k < N; k++)
         {w_minus[k], w_dv[k], w_digits[4*k +: 4]} =
            f_dec(w_shreg_nxt[8*k +: 7]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sd          <= '0;
         r_sc          <= '0;
         r_sl          <= '0;
         r_sc_h        <= 1'b0;
         r_sl_h        <= 1'b0;
         r_shreg       <= '0;
         r_cnt         <= '0;
         o_frame       <= '0;
         o_digits      <= '0;
         o_digit_valid <= '0;
         o_minus       <= '0;
         o_valid       <= 1'b0;
         o_frame_error <= 1'b0;
         o_overrun     <= 1'b0;
      end else begin
         r_sd          <= {r_sd[SYNC_STAGES-2:0], i_sr_data};
         r_sc          <= {r_sc[SYNC_STAGES-2:0], i_sr_clk};
         r_sl          <= {r_sl[SYNC_STAGES-2:0], i_sr_latch};
         r_sc_h        <= r_sc[SYNC_STAGES-1];
         r_sl_h        <= r_sl[SYNC_STAGES-1];
         r_shreg       <= w_shreg_nxt;
         r_cnt         <= w_latch ? '0 : w_cnt_nxt;
         o_frame_error <= w_latch & ~w_load;
         o_overrun     <= w_load & o_valid & ~i_ready;
         if (w_load) begin
            o_frame       <= w_shreg_nxt;
            o_digits      <= w_digits;
            o_digit_valid <= w_dv;
            o_minus       <= w_minus;
            o_valid       <= 1'b1;
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule
